rsa_modexp_serial: RTL

//  Parametrised modular exponentiation engine: result = base^exp mod modulus.

---
 rtl/rsa_pkg.sv | 23 ++
 rtl/rsa_modexp_serial_if.sv | 17 +
 rtl/rsa_modmul_serial.sv | 68 ++++++
 rtl/rsa_modexp_serial.sv | 120 ++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// Shared types and helpers for the serial modular exponentiation engine.
package rsa_pkg;

  // The one-cycle completion slot is held by a separate flag, so the 8 states fit in 3 bits.
  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ERR,
    S_SQ,
    S_SQ_W,
    S_MUL,
    S_MUL_W,
    S_NEXT
  } state_t;

  function automatic int popcount(input logic [63:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 64; i++) n += int'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/rsa_modexp_serial_if.sv
// Start/done request bus between the RSA controller and the exponentiation engine.
interface rsa_modexp_serial_if #(
  parameter int K   = 12,
  parameter int E_W = 12
);
  logic           start;
  logic [K-1:0]   base;
  logic [E_W-1:0] exp;
  logic [K-1:0]   modulus;
  logic           busy;
  logic           done;
  logic [K-1:0]   result;
  logic           err;

  modport master (output start, base, exp, modulus, input busy, done, result, err);
  modport slave  (input start, base, exp, modulus, output busy, done, result, err);
endinterface

// File: rtl/rsa_modmul_serial.sv
// Bit-serial interleaved modular multiplier: p = a*b mod m, one bit of b per cycle, MSB first.
module rsa_modmul_serial #(
  parameter int K = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         mm_start,
  input  logic [K-1:0] a,
  input  logic [K-1:0] b,
  input  logic [K-1:0] m,
  output logic         mm_done,
  output logic [K-1:0] p
);

  localparam int IW = (K > 1) ? $clog2(K) : 1;

  logic          running;
  logic [IW-1:0] idx;
  logic [K-1:0]  a_r, b_r, m_r, c;
  logic [K-1:0]  b_sh, dbl, sum, c_next;

  // Inputs are below the modulus, so a single conditional subtract fully reduces.
  function automatic logic [K-1:0] reduce(input logic [K:0] x, input logic [K-1:0] mod);
    return K'((x >= {1'b0, mod}) ? x - {1'b0, mod} : x);
  endfunction

  always_comb begin
    b_sh   = b_r >> idx;
    dbl    = reduce({c, 1'b0}, m_r);
    sum    = reduce({1'b0, dbl} + {1'b0, a_r}, m_r);
    c_next = b_sh[0] ? sum : dbl;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      running <= 1'b0;
      mm_done <= 1'b0;
      idx     <= '0;
    end else begin
      mm_done <= 1'b0;
      if (mm_start) begin
        running <= 1'b1;
        idx     <= IW'(K - 1);
      end else if (running) begin
        if (idx == '0) begin
          running <= 1'b0;
          mm_done <= 1'b1;
        end else begin
          idx <= idx - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mm_start) begin
      a_r <= a;
      b_r <= b;
      m_r <= m;
      c   <= '0;
    end else if (running) begin
      c <= c_next;
    end
  end

  assign p = c;

endmodule

// File: rtl/rsa_modexp_serial.sv
// Left-to-right square-and-multiply modular exponentiation over a serial modular multiplier.
module rsa_modexp_serial
  import rsa_pkg::*;
#(
  parameter int K          = 12,
  parameter int E_W        = 12,
  parameter int CONST_TIME = 0
) (
  input  logic               clk,
  input  logic               rst,
  rsa_modexp_serial_if.slave bus
);

  localparam int CW = $clog2(E_W + 1);

  state_t         state;
  logic [K-1:0]   base_r, mod_r, acc;
  logic [E_W-1:0] exp_r, exp_sh;
  logic [CW-1:0]  cnt;
  logic           fin, err_p, accept, cur_bit;
  logic           mm_start, mm_done;
  logic [K-1:0]   mm_b, mm_p;
  logic [31:0]    lat_cnt, exp_lat;

  // fin marks the completion cycle; start is ignored there and in the following done cycle.
  assign accept   = (state == S_IDLE) && bus.start && !fin && !bus.done;
  assign exp_sh   = exp_r >> cnt;
  assign cur_bit  = exp_sh[0];
  assign mm_start = (state == S_SQ) || (state == S_MUL);
  assign mm_b     = (state == S_MUL) ? base_r : acc;

  rsa_modmul_serial #(.K(K)) u_mm (
    .clk      (clk),
    .rst      (rst),
    .mm_start (mm_start),
    .a        (acc),
    .b        (mm_b),
    .m        (mod_r),
    .mm_done  (mm_done),
    .p        (mm_p)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      fin        <= 1'b0;
      err_p      <= 1'b0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.result <= '0;
      bus.err    <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      fin      <= 1'b0;
      if (fin) begin
        bus.done   <= 1'b1;
        bus.busy   <= 1'b0;
        bus.result <= err_p ? '0 : acc;
        bus.err    <= err_p;
      end
      case (state)
        S_IDLE: if (accept) begin
          state    <= S_CHECK;
          bus.busy <= 1'b1;
        end
        S_CHECK: if ((mod_r < K'(2)) || (base_r >= mod_r)) begin
          err_p <= 1'b1;
          state <= S_ERR;
        end else begin
          err_p <= 1'b0;
          cnt   <= CW'(E_W);
          state <= S_NEXT;
        end
        S_ERR: begin
          fin   <= 1'b1;
          state <= S_IDLE;
        end
        // NEXT selects the following exponent bit; it runs once more than there are bits.
        S_NEXT: if (cnt == '0) begin
          fin   <= 1'b1;
          state <= S_IDLE;
        end else begin
          cnt   <= cnt - 1'b1;
          state <= S_SQ;
        end
        S_SQ:    state <= S_SQ_W;
        S_SQ_W:  if (mm_done) state <= (cur_bit || (CONST_TIME != 0)) ? S_MUL : S_NEXT;
        S_MUL:   state <= S_MUL_W;
        S_MUL_W: if (mm_done) state <= S_NEXT;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      base_r <= bus.base;
      exp_r  <= bus.exp;
      mod_r  <= bus.modulus;
    end
    if (state == S_CHECK) acc <= K'(1);
    // A dummy multiply (exponent bit 0) computes but never commits its product.
    if (mm_done && ((state == S_SQ_W) || ((state == S_MUL_W) && cur_bit))) acc <= mm_p;
  end

  assign exp_lat = err_p ? 32'd3 :
    32'(3 + E_W * (K + 3) + ((CONST_TIME != 0) ? E_W : popcount(64'(exp_r))) * (K + 2));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lat_cnt <= '0;
    else if (accept) lat_cnt <= '0;
    else lat_cnt <= lat_cnt + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst && fin) assert (lat_cnt + 32'd1 == exp_lat);
  end

endmodule
